// File: rtl/mov_wide_unit.sv
// mov_wide_unit: two-stage MOVZ/MOVK/MOVN execute unit with valid/ready and MOVK result forwarding
module mov_wide_unit #(
  parameter int DATA_WIDTH  = 64,
  parameter int SLICE_WIDTH = 16,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             op,
  input  logic [1:0]             shamt,
  input  logic [SLICE_WIDTH-1:0] imm,
  input  logic [REG_ADDR_W-1:0]  rd,
  input  logic [DATA_WIDTH-1:0]  old_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [REG_ADDR_W-1:0]  out_rd,
  output logic                   out_illegal
);
  localparam int NS = DATA_WIDTH / SLICE_WIDTH;
  localparam logic [1:0] OP_MOVK = 2'd1, OP_MOVN = 2'd2, OP_ILL = 2'd3;
  localparam logic [1:0] SEL_KEEP = 2'd0, SEL_IMM = 2'd1, SEL_ZERO = 2'd2;

  logic                   s1_valid_q, s1_valid_d;
  logic [1:0]             s1_op_q, s1_op_d;
  logic [1:0]             s1_shamt_q, s1_shamt_d;
  logic [SLICE_WIDTH-1:0] s1_imm_q, s1_imm_d;
  logic [REG_ADDR_W-1:0]  s1_rd_q, s1_rd_d;
  logic [DATA_WIDTH-1:0]  s1_old_q, s1_old_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0]  s2_data_q, s2_data_d;
  logic [REG_ADDR_W-1:0]  s2_rd_q, s2_rd_d;
  logic                   s2_illegal_q, s2_illegal_d;
  logic                   cr_valid_q, cr_valid_d;
  logic [DATA_WIDTH-1:0]  cr_data_q, cr_data_d;
  logic [REG_ADDR_W-1:0]  cr_rd_q, cr_rd_d;

  logic                   advance2, accept, move, xfer, s1_illegal;
  logic [DATA_WIDTH-1:0]  base, sliced, result;
  logic [NS-1:0][1:0]     sel;

  assign out_valid   = s2_valid_q;
  assign out_data    = s2_data_q;
  assign out_rd      = s2_rd_q;
  assign out_illegal = s2_illegal_q;

  // handshake, forwarding base selection, slice compute and next-state
  always_comb begin
    advance2   = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || advance2;
    accept     = in_valid && in_ready;
    move       = s1_valid_q && advance2;
    xfer       = s2_valid_q && out_ready;
    s1_illegal = (s1_op_q == OP_ILL) || ({1'b0, s1_shamt_q} >= 3'(NS));
    base = (&s1_rd_q) ? '0 :
           (s2_valid_q && !s2_illegal_q && s2_rd_q == s1_rd_q) ? s2_data_q :
           (cr_valid_q && cr_rd_q == s1_rd_q) ? cr_data_q : s1_old_q;
    sel    = '0;
    sliced = '0;
    for (int i = 0; i < NS; i++) begin
      sel[i] = s1_illegal ? SEL_ZERO :
               (2'(i) == s1_shamt_q) ? SEL_IMM :
               (s1_op_q == OP_MOVK) ? SEL_KEEP : SEL_ZERO;
      sliced[i*SLICE_WIDTH +: SLICE_WIDTH] = (sel[i] == SEL_KEEP) ? base[i*SLICE_WIDTH +: SLICE_WIDTH] :
                                             (sel[i] == SEL_IMM) ? s1_imm_q : '0;
    end
    result = (!s1_illegal && s1_op_q == OP_MOVN) ? ~sliced : sliced;
    s1_valid_d   = accept ? 1'b1 : (move ? 1'b0 : s1_valid_q);
    s1_op_d      = accept ? op : s1_op_q;
    s1_shamt_d   = accept ? shamt : s1_shamt_q;
    s1_imm_d     = accept ? imm : s1_imm_q;
    s1_rd_d      = accept ? rd : s1_rd_q;
    s1_old_d     = accept ? old_val : s1_old_q;
    s2_valid_d   = move ? 1'b1 : (xfer ? 1'b0 : s2_valid_q);
    s2_data_d    = move ? result : s2_data_q;
    s2_rd_d      = move ? s1_rd_q : s2_rd_q;
    s2_illegal_d = move ? s1_illegal : s2_illegal_q;
    cr_valid_d   = (xfer && !s2_illegal_q) ? 1'b1 : cr_valid_q;
    cr_data_d    = (xfer && !s2_illegal_q) ? s2_data_q : cr_data_q;
    cr_rd_d      = (xfer && !s2_illegal_q) ? s2_rd_q : cr_rd_q;
  end

  // pipeline and committed-record registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_shamt_q   <= '0;
      s1_imm_q     <= '0;
      s1_rd_q      <= '0;
      s1_old_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= '0;
      s2_rd_q      <= '0;
      s2_illegal_q <= 1'b0;
      cr_valid_q   <= 1'b0;
      cr_data_q    <= '0;
      cr_rd_q      <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_shamt_q   <= s1_shamt_d;
      s1_imm_q     <= s1_imm_d;
      s1_rd_q      <= s1_rd_d;
      s1_old_q     <= s1_old_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_rd_q      <= s2_rd_d;
      s2_illegal_q <= s2_illegal_d;
      cr_valid_q   <= cr_valid_d;
      cr_data_q    <= cr_data_d;
      cr_rd_q      <= cr_rd_d;
    end
  end
endmodule
